// File: rtl/mem_block_copier.sv
// Bus initiator that copies a block of words within a single-port memory (read, wait, write per word).
// Optional running checksum of copied words when MEMCPY_CHECKSUM_EN is defined.
module mem_block_copier #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
`ifdef MEMCPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] write_data_reg, write_data_next;
`ifdef MEMCPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg, csum_next;
`endif

  // Output registers are loaded from next-state values so strobes line up with the state they belong to.
  always_comb begin
    state_next      = state_reg;
    src_ptr_next    = src_ptr_reg;
    dst_ptr_next    = dst_ptr_reg;
    rem_next        = rem_reg;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    address_next    = address_reg;
    write_data_next = write_data_reg;
`ifdef MEMCPY_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
`ifdef MEMCPY_CHECKSUM_EN
          csum_next = '0;
`endif
          if (len != '0) begin
            src_ptr_next  = src_base;
            dst_ptr_next  = dst_base;
            rem_next      = len;
            address_next  = src_base;
            mem_read_next = 1'b1;
            busy_next     = 1'b1;
            state_next    = S_RD;
          end else begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_RD: begin
        busy_next  = 1'b1;
        state_next = S_RWAIT;
      end
      S_RWAIT: begin
        // Memory returns the word in this cycle; capture it for the write.
        write_data_next = read_data;
        address_next    = dst_ptr_reg;
        mem_write_next  = 1'b1;
        busy_next       = 1'b1;
        state_next      = S_WR;
      end
      S_WR: begin
        src_ptr_next = src_ptr_reg + ADDR_W'(1);
        dst_ptr_next = dst_ptr_reg + ADDR_W'(1);
        rem_next     = rem_reg - LEN_W'(1);
`ifdef MEMCPY_CHECKSUM_EN
        csum_next    = csum_reg + write_data_reg;
`endif
        if (rem_reg == LEN_W'(1)) begin
          done_next  = 1'b1;
          state_next = S_DONE;
        end else begin
          address_next  = src_ptr_reg + ADDR_W'(1);
          mem_read_next = 1'b1;
          busy_next     = 1'b1;
          state_next    = S_RD;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      src_ptr_reg    <= '0;
      dst_ptr_reg    <= '0;
      rem_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      address_reg    <= '0;
      write_data_reg <= '0;
`ifdef MEMCPY_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      src_ptr_reg    <= src_ptr_next;
      dst_ptr_reg    <= dst_ptr_next;
      rem_reg        <= rem_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      address_reg    <= address_next;
      write_data_reg <= write_data_next;
`ifdef MEMCPY_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign address    = address_reg;
  assign write_data = write_data_reg;
`ifdef MEMCPY_CHECKSUM_EN
  assign checksum   = csum_reg;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: table of copy jobs checked through a read/write scoreboard,
// plus a hand-written mid-copy reset sequence. Checks checksum when MEMCPY_CHECKSUM_EN is defined.
module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] src_base = '0;
  logic [11:0] dst_base = '0;
  logic [11:0] len = '0;
  logic        busy, done, mem_read, mem_write;
  logic [11:0] address, write_data;
  logic [11:0] read_data;
`ifdef MEMCPY_CHECKSUM_EN
  logic [11:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_block_copier #(.ADDR_W(12), .DATA_W(12), .LEN_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
`ifdef MEMCPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // Single-port memory: registered read, read wins over write; extra preload port for the bench.
  logic [11:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [11:0] pl_data = '0;
  always @(posedge clk) begin
    if (mem_read) read_data <= mem[address];
    else if (mem_write) mem[address] <= write_data;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
  } wr_t;
  wr_t         wq[$];
  logic [11:0] rq[$];

  typedef struct {
    logic [11:0] src;
    logic [11:0] dst;
    logic [11:0] n;
    int          seed;
    int          disturb;
    int          lat;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; DUT outputs are observed on the falling edge and matched against the scoreboard.
  task automatic tick();
    wr_t w;
    logic [11:0] ra;
    @(posedge clk);
    @(negedge clk);
    if (mem_read && mem_write) check("rw_exclusive", 1, 0);
    if (mem_write) begin
      if (wq.size() == 0) check("unexpected_write_addr", int'(address), -1);
      else begin
        w = wq.pop_front();
        check("wr_addr", int'(address), int'(w.addr));
        check("wr_data", int'(write_data), int'(w.data));
      end
    end
    if (mem_read) begin
      if (rq.size() == 0) check("unexpected_read_addr", int'(address), -1);
      else begin
        ra = rq.pop_front();
        check("rd_addr", int'(address), int'(ra));
      end
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  function automatic logic [11:0] pat(input int seed, input int i);
    logic [11:0] t1 [10];
    t1 = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd0, 12'd2, 12'd4, 12'd0, 12'd1};
    if (seed == 0) return t1[i];
    return 12'(seed * 37 + i * 11 + 5);
  endfunction

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input logic [11:0] n,
                          input int seed, input int disturb, input int exp_lat);
    logic [11:0] sum;
    int lat;
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      preload(s + 12'(i), pat(seed, i));
      rq.push_back(s + 12'(i));
      wq.push_back('{addr: d + 12'(i), data: pat(seed, i)});
      sum = sum + pat(seed, i);
    end
    done_cnt = 0;
    busy_cnt = 0;
    src_base = s;
    dst_base = d;
    len = n;
    start = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        src_base = ~s;
        dst_base = d + 12'd100;
        len = 12'd7;
        check("busy_after_accept", int'(busy), int'(n != 0));
      end
      start = (disturb != 0 && lat == disturb);
    end while (!done && lat < 3 * int'(n) + 20);
    start = 1'b0;
    check("done_latency", lat, exp_lat);
`ifdef MEMCPY_CHECKSUM_EN
    check("checksum_at_done", int'(checksum), int'(sum));
`endif
    tick();
    check("done_pulses", done_cnt, 1);
    check("done_low_after", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("busy_cycles", busy_cnt, 3 * int'(n));
`ifdef MEMCPY_CHECKSUM_EN
    check("checksum_hold", int'(checksum), int'(sum));
`endif
    check("reads_pending", rq.size(), 0);
    check("writes_pending", wq.size(), 0);
    rq.delete();
    wq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{src: 12'd1000, dst: 12'd3000, n: 12'd10, seed: 0, disturb: 0, lat: 31};
    vecs[1] = '{src: 12'd1500, dst: 12'd1600, n: 12'd0,  seed: 1, disturb: 0, lat: 1};
    vecs[2] = '{src: 12'd2000, dst: 12'd2100, n: 12'd6,  seed: 3, disturb: 5, lat: 19};
    vecs[3] = '{src: 12'd4094, dst: 12'd10,   n: 12'd4,  seed: 5, disturb: 0, lat: 13};
    vecs[4] = '{src: 12'd700,  dst: 12'd800,  n: 12'd1,  seed: 9, disturb: 2, lat: 4};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_read", int'(mem_read), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_address", int'(address), 0);
    check("rst_write_data", int'(write_data), 0);
`ifdef MEMCPY_CHECKSUM_EN
    check("rst_checksum", int'(checksum), 0);
`endif
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].seed, vecs[v].disturb, vecs[v].lat);
      tick();
    end

    // Reset during the RWAIT of word 3 of a 10-word copy
    for (int i = 0; i < 10; i++) begin
      preload(12'd1200 + 12'(i), pat(11, i));
      preload(12'd3200 + 12'(i), 12'h5A5);
    end
    for (int i = 0; i < 4; i++) rq.push_back(12'd1200 + 12'(i));
    for (int i = 0; i < 3; i++) wq.push_back('{addr: 12'd3200 + 12'(i), data: pat(11, i)});
    done_cnt = 0;
    src_base = 12'd1200;
    dst_base = 12'd3200;
    len = 12'd10;
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_mem_read", int'(mem_read), 0);
    check("mid_rst_mem_write", int'(mem_write), 0);
    check("mid_rst_address", int'(address), 0);
    check("mid_rst_write_data", int'(write_data), 0);
    for (int c = 0; c < 5; c++) tick();
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_reads_pending", rq.size(), 0);
    check("mid_rst_writes_pending", wq.size(), 0);
    rq.delete();
    wq.delete();
    for (int i = 0; i < 10; i++)
      check($sformatf("mid_rst_dst%0d", i), int'(mem[12'd3200 + 12'(i)]),
            (i < 3) ? int'(pat(11, i)) : int'(12'h5A5));

    // A fresh start after the aborted copy
    run_copy(12'd1200, 12'd3300, 12'd3, 11, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
